// File: rtl/testeio_mem_data_out_if.sv
// Bus and handshake bundle for testeio_mem_data_out.
// The Avalon-MM slave side (address/chipselect/write_n/writedata/readdata) and the
// core side (out_data/out_valid/out_ack) share one interface. The master modport is
// everything outside the block: the Nios II bus plus the serial core.
interface testeio_mem_data_out_if #(
  parameter int unsigned DATA_W = 32
);
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ack;

  modport master (
    output address, chipselect, write_n, writedata, out_ack,
    input  readdata, out_data, out_valid
  );

  modport slave (
    input  address, chipselect, write_n, writedata, out_ack,
    output readdata, out_data, out_valid
  );
endinterface

// File: rtl/testeio_mem_data_out.sv
// testeio_mem_data_out: Avalon-MM output port that hands a software-written word to
// the serial genetic-circuit core over a 4-phase out_valid/out_ack handshake and
// reports completion (done) or a stalled handshake (timeout) in STATUS.
// Optional feature macro: TESTEIO_MEM_DATA_OUT_IRQ_EN adds the irq port and the
// IRQ_MASK register at address 3.
module testeio_mem_data_out #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  testeio_mem_data_out_if.slave bus
`ifdef TESTEIO_MEM_DATA_OUT_IRQ_EN
  ,
  output logic                 irq
`endif
);

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYC - 1);

  state_t                 state;
  logic [DATA_W-1:0]      data_q;
  logic                   out_valid_q;
  logic                   done;
  logic                   timeout;
  logic [31:0]            timer;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic [31:0]            rdata;

  logic ack_s;
  logic wr;
  logic wr_data;
  logic wr_ctrl;
  logic wr_status;
  logic start;
  logic abort;
  logic busy;
  logic timer_last;
  logic unused_wd;

  assign wr         = bus.chipselect & ~bus.write_n;
  assign wr_data    = wr && (bus.address == 2'd0);
  assign wr_ctrl    = wr && (bus.address == 2'd1);
  assign wr_status  = wr && (bus.address == 2'd2);
  assign start      = wr_ctrl & bus.writedata[0];
  assign abort      = wr_ctrl & bus.writedata[1];
  assign busy       = (state != IDLE);
  assign ack_s      = ack_sync[SYNC_STAGES-1];
  assign timer_last = (TIMEOUT_CYC != 0) && (timer == TIMER_LAST);
  // Upper writedata bits are don't-care when DATA_W < 32.
  assign unused_wd  = ^bus.writedata;

  assign bus.out_data  = data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.readdata  = rdata;

  // Synchronise the asynchronous acknowledge into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ack_sync <= '0;
    else          ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.out_ack};
  end

  // DATA register; frozen while a transfer is in flight so out_data stays stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     data_q <= '0;
    else if (wr_data && state == IDLE) data_q <= bus.writedata[DATA_W-1:0];
  end

  // Handshake FSM with done/timeout flags.
  // The W1C clear is applied first so a same-cycle hardware set overrides it;
  // ABORT short-circuits the state case, giving it precedence over exit and timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      timer       <= '0;
    end else begin
      if (wr_status) begin
        if (bus.writedata[1]) done    <= 1'b0;
        if (bus.writedata[2]) timeout <= 1'b0;
      end
      if (abort) begin
        state       <= IDLE;
        out_valid_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              out_valid_q <= 1'b1;
              timer       <= '0;
              done        <= 1'b0;
              timeout     <= 1'b0;
              state       <= SEND;
            end
          end
          SEND: begin
            if (ack_s) begin
              out_valid_q <= 1'b0;
              timer       <= '0;
              state       <= RELEASE;
            end else if (timer_last) begin
              out_valid_q <= 1'b0;
              timeout     <= 1'b1;
              state       <= IDLE;
            end else begin
              timer <= timer + 32'd1;
            end
          end
          RELEASE: begin
            if (!ack_s) begin
              done  <= 1'b1;
              state <= IDLE;
            end else if (timer_last) begin
              timeout <= 1'b1;
              state   <= IDLE;
            end else begin
              timer <= timer + 32'd1;
            end
          end
          default: begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef TESTEIO_MEM_DATA_OUT_IRQ_EN
  logic [1:0] mask;

  // Interrupt mask register and registered interrupt output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr && bus.address == 2'd3) mask <= bus.writedata[1:0];
      irq <= (done & mask[0]) | (timeout & mask[1]);
    end
  end
`endif

  // Read mux, registered every cycle independent of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else begin
      case (bus.address)
        2'd0:    rdata <= 32'(data_q);
        2'd2:    rdata <= {29'b0, timeout, done, busy};
`ifdef TESTEIO_MEM_DATA_OUT_IRQ_EN
        2'd3:    rdata <= {30'b0, mask};
`endif
        default: rdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_testeio_mem_data_out.sv
// Bench for testeio_mem_data_out (DATA_W=8, SYNC_STAGES=2, TIMEOUT_CYC=16).
// The reference model predicts, per transfer, when out_valid falls, when busy ends
// and which flag is left set, from the handshake rules and the synchroniser latency.
module tb_testeio_mem_data_out;
  localparam int unsigned DW = 8;
  localparam int unsigned SS = 2;
  localparam int unsigned TO = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec   = 0;
  int   n_miss  = 0;

  logic [7:0] exp_data = '0;
  logic       exp_done = 1'b0;
  logic       exp_to   = 1'b0;
  logic [1:0] exp_mask = '0;

  testeio_mem_data_out_if #(.DATA_W(DW)) bus ();

`ifdef TESTEIO_MEM_DATA_OUT_IRQ_EN
  logic irq;
`endif

  testeio_mem_data_out #(
    .DATA_W(DW),
    .SYNC_STAGES(SS),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
`ifdef TESTEIO_MEM_DATA_OUT_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic irq_of(input logic d, input logic t);
    return (d & exp_mask[0]) | (t & exp_mask[1]);
  endfunction

  task automatic idle_bus();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd2;
  endtask

  task automatic drive_write(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    drive_write(a, d);
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic check_status(input string tag);
    logic [31:0] r;
    bus_read(2'd2, r);
    check(tag, r, {29'b0, exp_to, exp_done, 1'b0});
  endtask

  task automatic set_mask(input logic [1:0] m);
    logic [31:0] r;
    bus_write(2'd3, {30'h2AAAAAAA, m});
`ifdef TESTEIO_MEM_DATA_OUT_IRQ_EN
    exp_mask = m;
    bus_read(2'd3, r);
    check("mask_rd", r, {30'b0, m});
`else
    bus_read(2'd3, r);
    check("addr3_rd", r, 32'h0);
`endif
  endtask

  // bits[0] clears done, bits[1] clears timeout.
  task automatic w1c(input logic [1:0] bits);
    bus_write(2'd2, {29'h1FFFFFFF, bits[1], bits[0], 1'b1});
`ifdef TESTEIO_MEM_DATA_OUT_IRQ_EN
    check("irq_pre_w1c", 32'(irq), 32'(irq_of(exp_done, exp_to)));
`endif
    if (bits[0]) exp_done = 1'b0;
    if (bits[1]) exp_to   = 1'b0;
    @(negedge clk);
`ifdef TESTEIO_MEM_DATA_OUT_IRQ_EN
    check("irq_post_w1c", 32'(irq), 32'(irq_of(exp_done, exp_to)));
`endif
    check_status("status_w1c");
  endtask

  // One transfer. Times are negedges t after the clock edge that accepts START.
  // a: ack raise time (>13 means never raised); m: ack drop time after out_valid falls;
  // bp: attempt DATA+START writes while busy; ab_en/ab: ABORT written at RELEASE+ab.
  task automatic xfer(input logic [7:0] d, input int a, input int m,
                      input bit bp, input bit ab_en, input int ab);
    int fall_t, end_t, drop_t, last_t, ab_t;
    bit hs, post;
    logic fin_done, fin_to, f_d, f_t;
    logic [1:0]  last_drv;
    logic [31:0] wd;
    wd = $urandom;
    wd[7:0] = d;
    bus_write(2'd0, wd);
    exp_data = d;
    bus_write(2'd1, 32'h1);
    hs     = (a <= int'(TO) - int'(SS) - 1);
    fall_t = hs ? a + int'(SS) + 1 : int'(TO);
    drop_t = -1;
    if (!hs) begin
      end_t = int'(TO); fin_done = 1'b0; fin_to = 1'b1;
    end else begin
      drop_t = fall_t + m;
      if (ab_en) begin
        end_t = fall_t + ab + 1; fin_done = 1'b0; fin_to = 1'b0;
      end else if (m + int'(SS) + 1 <= int'(TO)) begin
        end_t = fall_t + m + int'(SS) + 1; fin_done = 1'b1; fin_to = 1'b0;
      end else begin
        end_t = fall_t + int'(TO); fin_done = 1'b0; fin_to = 1'b1;
      end
    end
    ab_t   = fall_t + ab;
    last_t = end_t + 2;
    if (drop_t + 1 > last_t) last_t = drop_t + 1;
    last_drv = 2'd1;
    for (int t = 0; t <= last_t; t++) begin
      if (t > 0) @(negedge clk);
      check("out_valid", 32'(bus.out_valid), 32'(t < fall_t));
      check("out_data", 32'(bus.out_data), 32'(exp_data));
      if (t >= 1) begin
        post = (t - 1 >= end_t);
        f_d  = post ? fin_done : 1'b0;
        f_t  = post ? fin_to : 1'b0;
        if (last_drv == 2'd2) check("status_live", bus.readdata, {29'b0, f_t, f_d, ~post});
`ifdef TESTEIO_MEM_DATA_OUT_IRQ_EN
        check("irq_live", 32'(irq), 32'(irq_of(f_d, f_t)));
`endif
      end
      idle_bus();
      if (hs && t == a) bus.out_ack = 1'b1;
      if (t == drop_t) bus.out_ack = 1'b0;
      if (bp && t == 1) drive_write(2'd0, 32'h22);
      if (bp && t == 2) drive_write(2'd1, 32'h1);
      if (hs && ab_en && t == ab_t) drive_write(2'd1, 32'h2);
      last_drv = bus.address;
    end
    idle_bus();
    bus.out_ack = 1'b0;
    repeat (SS + 2) @(negedge clk);
    exp_done = fin_done;
    exp_to   = fin_to;
    check_status("status_end");
  endtask

  initial begin
    logic [31:0] r;
    int a, m, ab;
    bit ab_en;
    bus.writedata = '0;
    bus.out_ack   = 1'b0;
    idle_bus();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    check("rst_readdata", bus.readdata, 32'h0);
`ifdef TESTEIO_MEM_DATA_OUT_IRQ_EN
    check("rst_irq", 32'(irq), 32'h0);
`endif
    check_status("rst_status");

    // Basic transfer: ack 3 cycles after out_valid, dropped 2 after it falls.
    xfer(8'hA5, 3, 2, 1'b0, 1'b0, 0);
    // Timeout: ack never raised.
    xfer(8'h5A, 99, 0, 1'b0, 1'b0, 0);
    w1c(2'b10);
    // Busy protection: DATA=0x22 and START while in SEND.
    xfer(8'h11, 5, 4, 1'b1, 1'b0, 0);
    // Abort in RELEASE.
    xfer(8'h77, 2, 6, 1'b0, 1'b1, 3);
    // Exit on the last cycle before timeout, and release that just misses.
    xfer(8'h3C, 13, 13, 1'b0, 1'b0, 0);
    xfer(8'hC3, 0, 14, 1'b0, 1'b0, 0);

    // ABORT+START in IDLE starts nothing.
    bus_write(2'd1, 32'h3);
    idle_bus();
    repeat (4) begin
      @(negedge clk);
      check("ctrl3_valid", 32'(bus.out_valid), 32'h0);
    end
    check_status("ctrl3_status");
    bus_read(2'd1, r);
    check("ctrl_rd", r, 32'h0);

    // DATA readback truncated to DATA_W.
    bus_write(2'd0, 32'hFFFF_FFFF);
    exp_data = 8'hFF;
    bus_read(2'd0, r);
    check("data_rd", r, 32'hFF);

    // Reset mid-SEND.
    bus_write(2'd1, 32'h1);
    idle_bus();
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_valid", 32'(bus.out_valid), 32'h1);
    check("pre_rst_status", bus.readdata, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'h0);
    check("async_rst_readdata", bus.readdata, 32'h0);
    check("async_rst_data", 32'(bus.out_data), 32'h0);
    @(negedge clk);
    reset_n  = 1'b1;
    exp_data = '0;
    exp_done = 1'b0;
    exp_to   = 1'b0;
    exp_mask = '0;
    @(negedge clk);
    check_status("post_rst_status");
    bus_read(2'd0, r);
    check("post_rst_data", r, 32'h0);

    // Interrupt on done, cleared by W1C; then masked off.
    set_mask(2'b01);
    xfer(8'h42, 4, 3, 1'b0, 1'b0, 0);
    w1c(2'b01);
    set_mask(2'b00);
    xfer(8'h24, 1, 1, 1'b0, 1'b0, 0);

    // Randomised transfers.
    for (int i = 0; i < 40; i++) begin
      set_mask(2'($urandom_range(0, 3)));
      a     = int'($urandom_range(0, 15));
      m     = int'($urandom_range(0, 17));
      ab_en = (a <= 13) && ($urandom_range(0, 3) == 0);
      ab    = int'($urandom_range(0, (m + 2 < 15) ? m + 2 : 15));
      xfer(8'($urandom), a, m, 1'($urandom_range(0, 1)), ab_en, ab);
      if ($urandom_range(0, 1) == 1) w1c(2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
